thru_wire_debounce: RTL and testbench

- Downstream consumer of the thru-wire echo path. Takes its 1-bit `out` signal, which may be asynchronous or bouncy.
- Produces a synchronized, debounced level, one-cycle rise/fall pulses, and a saturating edge counter.
- Sits between the raw echoed pin and any clocked logic that needs a clean single-bit event source.

---
 rtl/thru_wire_debounce.sv | 130 +++++++++++++
 tb/tb_thru_wire_debounce.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/thru_wire_debounce.sv
// Cleans up the echoed thru-wire signal: synchronizer, debounce FSM, one-cycle
// rise/fall pulses and a saturating, clearable transition counter.
module thru_wire_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in,
    input  logic                 clear_count,
    output logic                 level,
    output logic                 rise,
    output logic                 fall,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic [1:0]           o_dbg_state
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CNT_WIDTH-1:0] EDGE_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] EDGE_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic [CNT_WIDTH-1:0]   r_edge_count;

    // Only the synchronizer touches the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_LOW: begin
                    if (w_s) begin
                        r_state <= ST_RISE_WAIT;
                        r_cnt   <= CNT_ONE;
                    end
                end
                ST_RISE_WAIT: begin
                    if (!w_s) begin
                        r_state <= ST_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!w_s) begin
                        r_state <= ST_FALL_WAIT;
                        r_cnt   <= CNT_ONE;
                    end
                end
                ST_FALL_WAIT: begin
                    if (w_s) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_LOW;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Counts the registered pulse, so a clear in the pulse cycle still keeps that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_edge_count <= '0;
        end else if (r_rise || r_fall) begin
            if (clear_count) begin
                r_edge_count <= EDGE_ONE;
            end else if (r_edge_count != EDGE_MAX) begin
                r_edge_count <= r_edge_count + EDGE_ONE;
            end
        end else if (clear_count) begin
            r_edge_count <= '0;
        end
    end

    assign level       = r_level;
    assign rise        = r_rise;
    assign fall        = r_fall;
    assign edge_count  = r_edge_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_thru_wire_debounce.sv
// Bench for thru_wire_debounce: three parameter sets share one stimulus stream
// and are checked against a run-length reference model via expected queues.
module tb_thru_wire_debounce;

    logic clk;
    logic tb_rst_n;
    logic tb_in;
    logic tb_clear;

    logic       level0, rise0, fall0;
    logic [7:0] cnt0;
    logic [1:0] dbg0;
    logic       level1, rise1, fall1;
    logic [1:0] cnt1;
    logic [1:0] dbg1;
    logic       level2, rise2, fall2;
    logic [7:0] cnt2;
    logic [1:0] dbg2;

    localparam logic [1:0] DBG_LOW       = 2'd0;
    localparam logic [1:0] DBG_RISE_WAIT = 2'd1;

    thru_wire_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_WIDTH(8)) dut0 (
        .clk(clk), .rst_n(tb_rst_n), .in(tb_in), .clear_count(tb_clear),
        .level(level0), .rise(rise0), .fall(fall0), .edge_count(cnt0), .o_dbg_state(dbg0)
    );
    thru_wire_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(tb_rst_n), .in(tb_in), .clear_count(tb_clear),
        .level(level1), .rise(rise1), .fall(fall1), .edge_count(cnt1), .o_dbg_state(dbg1)
    );
    thru_wire_debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(2), .CNT_WIDTH(8)) dut2 (
        .clk(clk), .rst_n(tb_rst_n), .in(tb_in), .clear_count(tb_clear),
        .level(level2), .rise(rise2), .fall(fall2), .edge_count(cnt2), .o_dbg_state(dbg2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: per instance, in delayed by the synchronizer depth, then
    // the debounced level flips once s has differed from it for STABLE samples
    int p_sync[3]   = '{2, 2, 3};
    int p_stable[3] = '{4, 4, 2};
    int p_cmax[3]   = '{255, 3, 255};
    int m_hist[3];
    int m_level[3];
    int m_run[3];
    int m_cnt[3];
    int m_rise[3];
    int m_fall[3];

    logic [10:0] exp_q0[$];
    logic [10:0] exp_q1[$];
    logic [10:0] exp_q2[$];

    function automatic void model_step(input int i);
        int s;
        logic [10:0] e;
        if (!tb_rst_n) begin
            m_hist[i] = 0; m_level[i] = 0; m_run[i] = 0;
            m_cnt[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
        end else begin
            if (m_rise[i] != 0 || m_fall[i] != 0) begin
                if (tb_clear) m_cnt[i] = 1;
                else if (m_cnt[i] < p_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            end else if (tb_clear) begin
                m_cnt[i] = 0;
            end
            s = (m_hist[i] >> (p_sync[i] - 1)) & 1;
            m_hist[i] = ((m_hist[i] << 1) | int'(tb_in)) & ((1 << p_sync[i]) - 1);
            m_rise[i] = 0;
            m_fall[i] = 0;
            if (s != m_level[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == p_stable[i]) begin
                    m_level[i] = 1 - m_level[i];
                    m_rise[i]  = m_level[i];
                    m_fall[i]  = 1 - m_level[i];
                    m_run[i]   = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        e = {m_level[i][0], m_rise[i][0], m_fall[i][0], 8'(m_cnt[i])};
        case (i)
            0: exp_q0.push_back(e);
            1: exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) model_step(i);
        end
    end

    // scoreboard monitor
    function automatic void cmp(input int i, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL inst%0d outputs {level,rise,fall,count} @%0t: got %h expected %h",
                     i, $time, act, exp);
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q0.size() > 0) cmp(0, {level0, rise0, fall0, cnt0}, exp_q0.pop_front());
            if (exp_q1.size() > 0) cmp(1, {level1, rise1, fall1, 6'b0, cnt1}, exp_q1.pop_front());
            if (exp_q2.size() > 0) cmp(2, {level2, rise2, fall2, cnt2}, exp_q2.pop_front());
            n_checks++;
            if ((rise0 && fall0) || (rise1 && fall1) || (rise2 && fall2)) begin
                n_fail++;
                $display("FAIL rise_fall_exclusive @%0t: got rise&fall high together, required never", $time);
            end
        end
    end

    // driver tasks: each starts and ends at a falling edge
    task automatic hold(input logic v, input int n);
        tb_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_idle();
        tb_clear = 1'b1;
        @(negedge clk);
        tb_clear = 1'b0;
    endtask

    task automatic clear_on_fall();
        bit seen;
        seen = 0;
        tb_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fall1) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL fall_wait_timeout: got no fall pulse in 20 cycles, required one");
        end
        clear_idle();
    endtask

    task automatic check_dbg(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got state %0d required %0d", name, act, exp);
        end
    endtask

    initial begin
        tb_rst_n = 1'b0;
        tb_in    = 1'b0;
        tb_clear = 1'b0;
        repeat (3) @(negedge clk);
        tb_rst_n = 1'b1;

        // clean rise and fall
        hold(1'b1, 10);
        hold(1'b0, 10);

        // glitches from LOW: 3-cycle and 1-cycle highs
        hold(1'b1, 3);
        hold(1'b0, 10);
        hold(1'b1, 1);
        hold(1'b0, 10);

        // glitches from HIGH
        hold(1'b1, 10);
        hold(1'b0, 3);
        hold(1'b1, 10);
        hold(1'b0, 1);
        hold(1'b1, 10);

        // bounce into a final stable high
        hold(1'b0, 12);
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 1);
        hold(1'b1, 12);

        // saturation, clear on idle, clear with a fall pulse
        hold(1'b0, 10);
        repeat (5) begin
            hold(1'b1, 8);
            hold(1'b0, 8);
        end
        clear_idle();
        hold(1'b0, 3);
        hold(1'b1, 10);
        clear_on_fall();
        hold(1'b0, 10);

        // reset while in RISE_WAIT with cnt=2
        tb_in = 1'b1;
        repeat (4) @(negedge clk);
        check_dbg("mid_debounce_state", dbg0, DBG_RISE_WAIT);
        tb_rst_n = 1'b0;
        @(negedge clk);
        check_dbg("state_after_reset", dbg0, DBG_LOW);
        tb_rst_n = 1'b1;
        hold(1'b1, 10);

        // random runs with sporadic clears
        for (int r = 0; r < 60; r++) begin
            int n;
            tb_in = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 8);
            for (int c = 0; c < n; c++) begin
                tb_clear = ($urandom_range(0, 11) == 0);
                @(negedge clk);
            end
            tb_clear = 1'b0;
        end

        hold(1'b0, 12);
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q0.size() + exp_q1.size() + exp_q2.size() > 1) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending entries, required at most 1",
                     exp_q0.size() + exp_q1.size() + exp_q2.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
